// File: rtl/ps2_scan_sequencer_pkg.sv
// Shared types and constants for the PS/2 scan-code sequencer.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

    localparam int START   = 0;
    localparam int DATA_LO = 1;
    localparam int DATA_HI = 8;
    localparam int PARITY  = 9;
    localparam int STOP    = 10;

    localparam logic [7:0] CODE_EXT  = 8'hE0;
    localparam logic [7:0] CODE_BRK  = 8'hF0;
    localparam logic [7:0] CODE_ERR0 = 8'h00;
    localparam logic [7:0] CODE_ERR1 = 8'hFF;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } key_event_t;

endpackage

// File: rtl/ps2_scan_sequencer_if.sv
// Frame-receiver side and key-event consumer side of the sequencer.
interface ps2_scan_sequencer_if;
    logic        frame_valid;
    logic [10:0] frame;
    logic        rx_en;
    logic        key_valid;
    logic        key_ready;
    logic [7:0]  key_code;
    logic        key_ext;
    logic        key_release;

    modport master (
        input  frame_valid, frame, key_ready,
        output rx_en, key_valid, key_code, key_ext, key_release
    );

    modport slave (
        output frame_valid, frame, key_ready,
        input  rx_en, key_valid, key_code, key_ext, key_release
    );
endinterface

// File: rtl/ps2_scan_sequencer_event_fifo.sv
// Small key-event FIFO; pointers carry an extra wrap bit to tell full from empty.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  key_event_t push_data,
    output logic       full,
    output logic       valid,
    input  logic       ready,
    output key_event_t head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    key_event_t  mem [DEPTH];
    logic        pop;
    logic        push_ok;

    assign valid   = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = valid & ready;
    assign push_ok = push & (~full | pop);
    assign head    = valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)     rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/ps2_scan_sequencer.sv
// Checks PS/2 frames, folds E0/F0 prefixes into make/break events and queues them.
//
// state      | meaning
// -----------+---------------------------------------------
// S_IDLE     | no prefix pending
// S_EXT      | E0 seen, waiting for code or F0
// S_BRK      | F0 seen, next code is a break
// S_EXT_BRK  | E0 then F0 seen, next code is an extended break
module ps2_scan_sequencer
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    ps2_scan_sequencer_if.master        bus,
    output logic                        frame_err,
    output logic [7:0]                  err_count,
    output logic                        overflow
);
    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_EXT     = ST_EXT;
    localparam logic [1:0] S_BRK     = ST_BRK;
    localparam logic [1:0] S_EXT_BRK = ST_EXT_BRK;

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic [7:0]    data;
    logic          good;
    logic          emit;
    key_event_t    ev;
    logic          fifo_full;
    logic          fifo_valid;
    key_event_t    fifo_head;
    logic          pop;

    assign data = bus.frame[DATA_HI:DATA_LO];
    // Odd parity over data+parity bit; 00/FF are keyboard error codes, not keys.
    assign good = ~bus.frame[START] & bus.frame[STOP] & (^bus.frame[PARITY:DATA_LO])
                  & (data != CODE_ERR0) & (data != CODE_ERR1);
    assign tmo_hit = (state != S_IDLE) && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        ev        = '0;
        ev.code   = data;
        if (bus.frame_valid) begin
            if (!good) begin
                state_nxt = S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (data == CODE_EXT)      state_nxt = S_EXT;
                        else if (data == CODE_BRK) state_nxt = S_BRK;
                        else                       emit = 1'b1;
                    end
                    S_EXT: begin
                        if (data == CODE_BRK) begin
                            state_nxt = S_EXT_BRK;
                        end else if (data != CODE_EXT) begin
                            emit      = 1'b1;
                            ev.ext    = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end
                    S_BRK: begin
                        emit      = 1'b1;
                        ev.rel    = 1'b1;
                        state_nxt = S_IDLE;
                    end
                    default: begin
                        emit      = 1'b1;
                        ev.ext    = 1'b1;
                        ev.rel    = 1'b1;
                        state_nxt = S_IDLE;
                    end
                endcase
            end
        end else if (tmo_hit) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            frame_err <= 1'b0;
            err_count <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_err <= bus.frame_valid & ~good;
            if (bus.frame_valid & ~good & (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
            if (emit & fifo_full & ~pop)
                overflow <= 1'b1;
            if (bus.frame_valid)
                tmo_cnt <= '0;
            else if (tmo_hit)
                tmo_cnt <= '0;
            else if (state != S_IDLE)
                tmo_cnt <= tmo_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (emit),
        .push_data (ev),
        .full      (fifo_full),
        .valid     (fifo_valid),
        .ready     (bus.key_ready),
        .head      (fifo_head)
    );

    assign pop             = fifo_valid & bus.key_ready;
    assign bus.rx_en       = ~fifo_full;
    assign bus.key_valid   = fifo_valid;
    assign bus.key_code    = fifo_head.code;
    assign bus.key_ext     = fifo_head.ext;
    assign bus.key_release = fifo_head.rel;
endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed and randomized checks of ps2_scan_sequencer against an event-queue model.
module tb_ps2_scan_sequencer;
    localparam int TMO   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_err;
    logic [7:0] err_count;
    logic       overflow;

    ps2_scan_sequencer_if bus();

    ps2_scan_sequencer #(.TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .frame_err (frame_err),
        .err_count (err_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: pending prefix flags, idle count, queue of {code, ext, rel}
    logic [9:0] q[$];
    bit         pend_ext, pend_brk;
    int         idle_cnt;
    int         m_err;
    bit         m_ovf, m_ferr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input int kind);
        logic par, st, sp;
        par = ~(^d);
        st  = 1'b0;
        sp  = 1'b1;
        if (kind == 1) par = ~par;
        if (kind == 2) st = 1'b1;
        if (kind == 3) sp = 1'b0;
        return {sp, par, d, st};
    endfunction

    task automatic model_edge(input logic fv, input logic [10:0] fr, input logic rdy, input logic rst);
        logic [7:0] d;
        bit was_full, popped, bad, emit;
        logic [9:0] ev;
        if (rst) begin
            q.delete();
            pend_ext = 0; pend_brk = 0; idle_cnt = 0;
            m_err = 0; m_ovf = 0; m_ferr = 0;
            return;
        end
        d = fr[8:1];
        was_full = (q.size() == DEPTH);
        popped = 0;
        if (q.size() > 0 && rdy) begin
            void'(q.pop_front());
            popped = 1;
        end
        emit = 0;
        ev = '0;
        m_ferr = 0;
        if (fv) begin
            idle_cnt = 0;
            bad = fr[0] || !fr[10] || ($countones(fr[9:1]) % 2 == 0) || d == 8'h00 || d == 8'hFF;
            if (bad) begin
                m_ferr = 1;
                if (m_err < 255) m_err++;
                pend_ext = 0; pend_brk = 0;
            end else if (!pend_brk && d == 8'hE0) begin
                pend_ext = 1;
            end else if (!pend_brk && d == 8'hF0) begin
                pend_brk = 1;
            end else begin
                emit = 1;
                ev = {d, pend_ext, pend_brk};
                pend_ext = 0; pend_brk = 0;
            end
        end else if (pend_ext || pend_brk) begin
            idle_cnt++;
            if (idle_cnt == TMO) begin
                pend_ext = 0; pend_brk = 0; idle_cnt = 0;
            end
        end
        if (emit) begin
            if (was_full && !popped) m_ovf = 1;
            else q.push_back(ev);
        end
    endtask

    task automatic compare();
        chk("key_valid", bus.key_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("key_code", bus.key_code, q[0][9:2]);
            chk("key_ext", bus.key_ext, q[0][1]);
            chk("key_release", bus.key_release, q[0][0]);
        end
        chk("rx_en", bus.rx_en, q.size() < DEPTH);
        chk("frame_err", frame_err, m_ferr);
        chk("err_count", err_count, m_err);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic step(input logic fv, input logic [10:0] fr, input logic rdy, input logic rst);
        bus.frame_valid = fv;
        bus.frame       = fr;
        bus.key_ready   = rdy;
        reset           = rst;
        @(posedge clk);
        model_edge(fv, fr, rdy, rst);
        #1;
        compare();
    endtask

    task automatic send(input logic [7:0] d, input int kind, input logic rdy);
        step(1'b1, mk(d, kind), rdy, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 11'h0, rdy, 1'b0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_key_valid", bus.key_valid, 1'b0);
        chk("rst_key_code", bus.key_code, 8'h00);
        chk("rst_key_ext", bus.key_ext, 1'b0);
        chk("rst_key_release", bus.key_release, 1'b0);
        chk("rst_rx_en", bus.rx_en, 1'b1);
        chk("rst_err_count", err_count, 8'h00);
        chk("rst_overflow", overflow, 1'b0);
    endtask

    logic [7:0] bp_codes [5];
    int         r, c;
    logic [7:0] d;

    initial begin
        bus.frame_valid = 1'b0;
        bus.frame       = '0;
        bus.key_ready   = 1'b0;
        reset           = 1'b1;
        step(1'b0, 11'h0, 1'b0, 1'b1);
        step(1'b0, 11'h0, 1'b0, 1'b1);
        chk_reset_outputs();

        // make code, then pop
        send(8'h1C, 0, 1'b0);
        chk("make_valid", bus.key_valid, 1'b1);
        chk("make_code", bus.key_code, 8'h1C);
        idle(2, 1'b1);
        chk("make_popped", bus.key_valid, 1'b0);

        // extended break E0 F0 75
        send(8'hE0, 0, 1'b0);
        send(8'hF0, 0, 1'b0);
        chk("ext_brk_no_prefix_event", bus.key_valid, 1'b0);
        send(8'h75, 0, 1'b0);
        chk("ext_brk_code", bus.key_code, 8'h75);
        chk("ext_brk_flags", {bus.key_ext, bus.key_release}, 2'b11);
        idle(2, 1'b1);

        // bad frames
        send(8'h1C, 1, 1'b0);
        chk("bad_par_err", frame_err, 1'b1);
        chk("bad_par_cnt", err_count, 8'd1);
        idle(1, 1'b0);
        send(8'hF0, 0, 1'b0);
        send(8'h1C, 3, 1'b0);
        send(8'h1C, 0, 1'b0);
        chk("after_bad_rel", bus.key_release, 1'b0);
        idle(2, 1'b1);

        // prefix timeout boundary
        send(8'hF0, 0, 1'b0);
        idle(TMO, 1'b0);
        send(8'h1C, 0, 1'b0);
        chk("tmo16_rel", bus.key_release, 1'b0);
        idle(2, 1'b1);
        send(8'hF0, 0, 1'b0);
        idle(TMO - 1, 1'b0);
        send(8'h1C, 0, 1'b0);
        chk("tmo15_rel", bus.key_release, 1'b1);
        idle(2, 1'b1);

        // backpressure and overflow
        bp_codes = '{8'h15, 8'h16, 8'h1D, 8'h24, 8'h2D};
        for (int i = 0; i < 5; i++) send(bp_codes[i], 0, 1'b0);
        chk("bp_rx_en", bus.rx_en, 1'b0);
        chk("bp_overflow", overflow, 1'b1);
        send(8'h2E, 0, 1'b1);
        chk("full_push_pop_rx_en", bus.rx_en, 1'b0);
        chk("full_push_pop_head", bus.key_code, 8'h16);
        idle(6, 1'b1);

        // reset while in EXT_BRK with queued events
        send(8'h1C, 0, 1'b0);
        send(8'h1B, 0, 1'b0);
        send(8'hE0, 0, 1'b0);
        send(8'hF0, 0, 1'b0);
        step(1'b0, 11'h0, 1'b0, 1'b1);
        chk_reset_outputs();
        send(8'h75, 0, 1'b0);
        chk("post_rst_flags", {bus.key_ext, bus.key_release}, 2'b00);
        idle(2, 1'b1);

        // err_count saturation
        for (int i = 0; i < 260; i++) begin
            if (i % 4 == 0) send(8'h00, 0, 1'b1);
            else if (i % 4 == 1) send(8'hFF, 0, 1'b1);
            else send(8'h3A, i % 4, 1'b1);
        end
        chk("err_sat", err_count, 8'hFF);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 35) begin
                c = $urandom_range(0, 9);
                d = 8'($urandom_range(1, 254));
                if (c < 2)       send(8'hE0, 0, $urandom_range(0, 2) == 0);
                else if (c < 4)  send(8'hF0, 0, $urandom_range(0, 2) == 0);
                else if (c == 4) send(d, $urandom_range(1, 3), $urandom_range(0, 2) == 0);
                else if (c == 5) send(($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF, 0, 1'b1);
                else             send(d, 0, $urandom_range(0, 2) == 0);
            end else if (r < 38) begin
                idle($urandom_range(TMO - 3, TMO + 2), $urandom_range(0, 1) == 0);
            end else if (r < 39) begin
                step(1'b0, 11'h0, 1'b0, 1'b1);
            end else begin
                idle(1, $urandom_range(0, 2) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
